// File: rtl/heap_pkg.sv
// Shared constants and state encodings for the heap request arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package heap_pkg;

    localparam logic HEAP_OP_PUSH = 1'b0;
    localparam logic HEAP_OP_POP  = 1'b1;

    localparam int KEY_W_DEF = 32;
    localparam int CNT_W_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or above ptr, wrapping modulo NUM_REQ.
// Latency: combinational.
// Backpressure: none; the caller decides whether the grant is used.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       gnt_vld
);
    localparam int PTR_W = $clog2(NUM_REQ);

    int idx_w;

    // Walk the requesters starting at ptr; the first one found wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx_w   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx_w = int'(ptr) + off;
            if (idx_w >= NUM_REQ) begin
                idx_w = idx_w - NUM_REQ;
            end
            if (!gnt_vld && req[idx_w]) begin
                gnt_vld      = 1'b1;
                gnt[idx_w]   = 1'b1;
                gnt_idx      = PTR_W'(idx_w);
            end
        end
    end

endmodule

// File: rtl/heap_req_arbiter.sv
// Shares one heap engine among NUM_REQ requesters, one op in flight, with empty/full screening and a done watchdog.
// Latency: refusal responds 2 cycles after req_ready; issued ops respond the cycle after heap_done (or watchdog expiry).
// Backpressure: req_ready is withheld from every requester while an op is in flight.
module heap_req_arbiter
    import heap_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int KEY_W   = KEY_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MAX_CNT = 1023,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_op,
    input  logic [NUM_REQ*KEY_W-1:0] req_key,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [KEY_W-1:0]         rsp_key,
    output logic                     rsp_err,
    output logic                     heap_start,
    output logic                     heap_op,
    output logic [KEY_W-1:0]         heap_key,
    input  logic                     heap_done,
    input  logic [CNT_W-1:0]         heap_cnt,
    input  logic [KEY_W-1:0]         heap_top,
    output logic                     busy
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    arb_state_e         state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   gidx_q, gidx_d;
    logic               op_q, op_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [KEY_W-1:0]   top_q, top_d;
    logic               err_q, err_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;

    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_vld;
    logic               refuse;
    logic               hold;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Screening decision; only acted on in CHECK, where heap_cnt is the engine's current occupancy.
    assign refuse = ((op_q == HEAP_OP_POP)  && (heap_cnt == '0)) ||
                    ((op_q == HEAP_OP_PUSH) && (heap_cnt == CNT_W'(MAX_CNT)));

    // Engine op/key are presented from the start pulse until done (or watchdog).
    assign hold = ((state_q == ST_CHECK) && !refuse) || (state_q == ST_WAIT);

    // Next-state, latches and strobes for the request FSM.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gidx_d     = gidx_q;
        op_d       = op_q;
        key_d      = key_q;
        top_d      = top_q;
        err_d      = err_q;
        tmr_d      = tmr_q;
        req_ready  = '0;
        heap_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    // Ready is masked in reset so nothing looks accepted while the FSM is held.
                    req_ready = gnt & {NUM_REQ{reset_n}};
                    gidx_d    = gnt_idx;
                    op_d      = req_op[gnt_idx];
                    key_d     = req_key[int'(gnt_idx)*KEY_W +: KEY_W];
                    err_d     = 1'b0;
                    rr_ptr_d  = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (refuse) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    // The root before the pop is the value the pop removes.
                    top_d      = heap_top;
                    heap_start = 1'b1;
                    tmr_d      = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (heap_done) begin
                    state_d = ST_RESP;
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (tmr_q != {TMR_W{1'b1}}) begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latch registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            op_q     <= 1'b0;
            key_q    <= '0;
            top_q    <= '0;
            err_q    <= 1'b0;
            tmr_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            op_q     <= op_d;
            key_q    <= key_d;
            top_q    <= top_d;
            err_q    <= err_d;
            tmr_q    <= tmr_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP) ? (NUM_REQ'(1) << gidx_q) : '0;
    assign rsp_err   = (state_q == ST_RESP) && err_q;
    assign rsp_key   = ((state_q == ST_RESP) && (op_q == HEAP_OP_POP) && !err_q) ? top_q : '0;
    assign heap_op   = hold && op_q;
    assign heap_key  = hold ? key_q : '0;
    assign busy      = (state_q != ST_IDLE);

endmodule
